// File: rtl/emperor_axi_lite_regs.sv
// emperor_axi_lite_regs: AXI4-Lite slave exposing NUM_REGS byte-writable 32-bit registers.
module emperor_axi_lite_regs #(
    parameter int          NUM_REGS  = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                   aclk,
    input  logic                   arst,
    input  logic [31:0]            S_AXI_awaddr,
    input  logic [2:0]             S_AXI_awprot,
    input  logic                   S_AXI_awvalid,
    output logic                   S_AXI_awready,
    input  logic [31:0]            S_AXI_wdata,
    input  logic [3:0]             S_AXI_wstrb,
    input  logic                   S_AXI_wvalid,
    output logic                   S_AXI_wready,
    output logic [1:0]             S_AXI_bresp,
    output logic                   S_AXI_bvalid,
    input  logic                   S_AXI_bready,
    input  logic [31:0]            S_AXI_araddr,
    input  logic [2:0]             S_AXI_arprot,
    input  logic                   S_AXI_arvalid,
    output logic                   S_AXI_arready,
    output logic [31:0]            S_AXI_rdata,
    output logic [1:0]             S_AXI_rresp,
    output logic                   S_AXI_rvalid,
    input  logic                   S_AXI_rready,
    output logic [NUM_REGS*32-1:0] reg_q,
    output logic [NUM_REGS-1:0]    reg_wr_stb
);
    typedef enum logic [1:0] {W_IDLE, W_HAVE_A, W_HAVE_D, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    w_state_t w_state, w_next;
    r_state_t r_state, r_next;
    logic [31:0] regs [NUM_REGS];
    logic [29:0] aw_idx_q, wr_idx;
    logic [31:0] wdata_q, wr_data, rd_val;
    logic [3:0] wstrb_q, wr_strb;
    logic [NUM_REGS-1:0] wr_onehot;
    logic aw_hs, w_hs, ar_hs, commit, wr_in_range, rd_in_range;
    logic unused;
    assign unused = ^{S_AXI_awprot, S_AXI_arprot, S_AXI_awaddr[1:0], S_AXI_araddr[1:0]};
    assign aw_hs = S_AXI_awvalid && S_AXI_awready;
    assign w_hs = S_AXI_wvalid && S_AXI_wready;
    assign ar_hs = S_AXI_arvalid && S_AXI_arready;
    // The final handshake's values bypass the holding registers so commit happens on that edge.
    assign wr_idx = aw_hs ? S_AXI_awaddr[31:2] : aw_idx_q;
    assign wr_data = w_hs ? S_AXI_wdata : wdata_q;
    assign wr_strb = w_hs ? S_AXI_wstrb : wstrb_q;
    assign commit = (w_next == W_RESP) && (w_state != W_RESP);
    assign wr_in_range = wr_idx < 30'(NUM_REGS);
    assign rd_in_range = S_AXI_araddr[31:2] < 30'(NUM_REGS);
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:   w_next = (aw_hs && w_hs) ? W_RESP : aw_hs ? W_HAVE_A : w_hs ? W_HAVE_D : W_IDLE;
            W_HAVE_A: w_next = w_hs ? W_RESP : W_HAVE_A;
            W_HAVE_D: w_next = aw_hs ? W_RESP : W_HAVE_D;
            default:  w_next = (S_AXI_bvalid && S_AXI_bready) ? W_IDLE : W_RESP;
        endcase
        r_next = (r_state == R_IDLE) ? (ar_hs ? R_DATA : R_IDLE)
                                     : ((S_AXI_rvalid && S_AXI_rready) ? R_IDLE : R_DATA);
        rd_val = '0;
        wr_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (S_AXI_araddr[31:2] == 30'(i)) rd_val = regs[i];
            wr_onehot[i] = commit && wr_in_range && (wr_idx == 30'(i));
        end
    end
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            w_state       <= W_IDLE;
            r_state       <= R_IDLE;
            S_AXI_awready <= 1'b0;
            S_AXI_wready  <= 1'b0;
            S_AXI_arready <= 1'b0;
            S_AXI_bvalid  <= 1'b0;
            S_AXI_rvalid  <= 1'b0;
            S_AXI_bresp   <= 2'b00;
            S_AXI_rresp   <= 2'b00;
            S_AXI_rdata   <= '0;
            reg_wr_stb    <= '0;
            aw_idx_q      <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
        end else begin
            w_state       <= w_next;
            r_state       <= r_next;
            S_AXI_awready <= (w_next == W_IDLE) || (w_next == W_HAVE_D);
            S_AXI_wready  <= (w_next == W_IDLE) || (w_next == W_HAVE_A);
            S_AXI_bvalid  <= w_next == W_RESP;
            S_AXI_arready <= r_next == R_IDLE;
            S_AXI_rvalid  <= r_next == R_DATA;
            reg_wr_stb    <= wr_onehot;
            if (aw_hs) aw_idx_q <= S_AXI_awaddr[31:2];
            if (w_hs) begin
                wdata_q <= S_AXI_wdata;
                wstrb_q <= S_AXI_wstrb;
            end
            if (commit) S_AXI_bresp <= wr_in_range ? 2'b00 : 2'b10;
            if (ar_hs) begin
                S_AXI_rdata <= rd_in_range ? rd_val : 32'h0;
                S_AXI_rresp <= rd_in_range ? 2'b00 : 2'b10;
            end
        end
    end
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++)
                for (int b = 0; b < 4; b++)
                    if (wr_onehot[i] && wr_strb[b]) regs[i][8*b+:8] <= wr_data[8*b+:8];
        end
    end
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
        assign reg_q[32*i+:32] = regs[i];
    end
endmodule

// File: tb/tb_emperor_axi_lite_regs.sv
// tb_emperor_axi_lite_regs: directed self-checking bench for emperor_axi_lite_regs.
module tb_emperor_axi_lite_regs;
    localparam int          N  = 8;
    localparam logic [31:0] RV = 32'h1111_2222;
    logic aclk = 0, arst = 1;
    logic [31:0] awaddr = 0, wdata = 0, araddr = 0, rdata;
    logic [2:0] awprot = 0, arprot = 0;
    logic [3:0] wstrb = 0;
    logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
    logic awready, wready, bvalid, arready, rvalid;
    logic [1:0] bresp, rresp;
    logic [N*32-1:0] reg_q;
    logic [N-1:0] reg_wr_stb;
    logic [31:0] model [N];
    int tests = 0, fails = 0;
    emperor_axi_lite_regs #(.NUM_REGS(N), .RESET_VAL(RV)) dut (
        .aclk(aclk), .arst(arst),
        .S_AXI_awaddr(awaddr), .S_AXI_awprot(awprot), .S_AXI_awvalid(awvalid), .S_AXI_awready(awready),
        .S_AXI_wdata(wdata), .S_AXI_wstrb(wstrb), .S_AXI_wvalid(wvalid), .S_AXI_wready(wready),
        .S_AXI_bresp(bresp), .S_AXI_bvalid(bvalid), .S_AXI_bready(bready),
        .S_AXI_araddr(araddr), .S_AXI_arprot(arprot), .S_AXI_arvalid(arvalid), .S_AXI_arready(arready),
        .S_AXI_rdata(rdata), .S_AXI_rresp(rresp), .S_AXI_rvalid(rvalid), .S_AXI_rready(rready),
        .reg_q(reg_q), .reg_wr_stb(reg_wr_stb)
    );
    always #5 aclk = ~aclk;
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
    function automatic logic [N*32-1:0] packed_model();
        logic [N*32-1:0] v;
        for (int i = 0; i < N; i++) v[32*i+:32] = model[i];
        return v;
    endfunction
    task automatic step();
        @(posedge aclk);
        #1;
    endtask
    task automatic test_reset();
        for (int i = 0; i < N; i++) model[i] = RV;
        step();
        step();
        tests++; if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin fails++; $display("FAIL reset_ready: got %b expected 00000", {awready, wready, arready, bvalid, rvalid}); end
        tests++; if (reg_q !== packed_model()) begin fails++; $display("FAIL reset_regs: got %h expected %h", reg_q, packed_model()); end
        tests++; if ({bresp, rresp, rdata, reg_wr_stb} !== '0) begin fails++; $display("FAIL reset_resp: got %h expected 0", {bresp, rresp, rdata, reg_wr_stb}); end
        arst = 0;
        #1;
        tests++; if (awready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b expected 0", awready); end
        step();
        tests++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL ready_after_edge: got %b expected 111", {awready, wready, arready}); end
    endtask
    task automatic test_same_cycle_write();
        awaddr = 32'h4; awvalid = 1; wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        model[1] = 32'hDEAD_BEEF;
        tests++; if ({bvalid, bresp} !== 3'b100) begin fails++; $display("FAIL same_bvalid: got %b expected 100", {bvalid, bresp}); end
        tests++; if (reg_wr_stb !== 8'h02) begin fails++; $display("FAIL same_stb: got %h expected 02", reg_wr_stb); end
        tests++; if (reg_q[63:32] !== 32'hDEAD_BEEF) begin fails++; $display("FAIL same_reg1: got %h expected deadbeef", reg_q[63:32]); end
        tests++; if ({awready, wready} !== 2'b00) begin fails++; $display("FAIL same_ready_resp: got %b expected 00", {awready, wready}); end
        bready = 1;
        step();
        bready = 0;
        tests++; if ({bvalid, reg_wr_stb} !== 9'h0) begin fails++; $display("FAIL same_done: got %h expected 0", {bvalid, reg_wr_stb}); end
        tests++; if ({awready, wready} !== 2'b11) begin fails++; $display("FAIL same_idle_ready: got %b expected 11", {awready, wready}); end
    endtask
    task automatic test_data_first();
        wdata = 32'h0000_00AB; wstrb = 4'h1; wvalid = 1;
        step();
        wvalid = 0;
        tests++; if ({awready, wready, bvalid} !== 3'b100) begin fails++; $display("FAIL dfirst_have_d: got %b expected 100", {awready, wready, bvalid}); end
        repeat (3) step();
        tests++; if (reg_q !== packed_model() || bvalid !== 1'b0) begin fails++; $display("FAIL dfirst_no_commit: got %h expected %h", reg_q, packed_model()); end
        awaddr = 32'h0; awvalid = 1;
        step();
        awvalid = 0;
        model[0] = 32'h1111_22AB;
        tests++; if (bvalid !== 1'b1 || reg_wr_stb !== 8'h01) begin fails++; $display("FAIL dfirst_commit: got %b/%h expected 1/01", bvalid, reg_wr_stb); end
        tests++; if (reg_q !== packed_model()) begin fails++; $display("FAIL dfirst_regs: got %h expected %h", reg_q, packed_model()); end
        bready = 1;
        step();
        bready = 0;
    endtask
    task automatic test_out_of_range();
        awaddr = 32'h20; awvalid = 1; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        tests++; if ({bvalid, bresp} !== 3'b110) begin fails++; $display("FAIL oor_bresp: got %b expected 110", {bvalid, bresp}); end
        tests++; if (reg_wr_stb !== 8'h00 || reg_q !== packed_model()) begin fails++; $display("FAIL oor_regs: got %h/%h expected 00/%h", reg_wr_stb, reg_q, packed_model()); end
        bready = 1;
        step();
        bready = 0;
        araddr = 32'h20; arvalid = 1;
        step();
        arvalid = 0;
        tests++; if ({rvalid, rresp, rdata} !== {1'b1, 2'b10, 32'h0}) begin fails++; $display("FAIL oor_read: got %b/%b/%h expected 1/10/0", rvalid, rresp, rdata); end
        rready = 1;
        step();
        rready = 0;
        tests++; if ({rvalid, arready} !== 2'b01) begin fails++; $display("FAIL oor_read_done: got %b expected 01", {rvalid, arready}); end
    endtask
    task automatic test_backpressure();
        awaddr = 32'hF; awvalid = 1; wdata = 32'h0BAD_F00D; wstrb = 4'hF; wvalid = 1;
        step();
        awvalid = 0; wvalid = 0;
        model[3] = 32'h0BAD_F00D;
        for (int k = 0; k < 5; k++) begin
            tests++; if ({bvalid, bresp, awready, wready} !== 5'b10000) begin fails++; $display("FAIL bp_write_hold%0d: got %b expected 10000", k, {bvalid, bresp, awready, wready}); end
            step();
        end
        bready = 1;
        step();
        bready = 0;
        tests++; if (bvalid !== 1'b0) begin fails++; $display("FAIL bp_write_done: got %b expected 0", bvalid); end
        araddr = 32'hC; arvalid = 1;
        step();
        arvalid = 0;
        for (int k = 0; k < 5; k++) begin
            tests++; if ({rvalid, arready, rresp, rdata} !== {1'b1, 1'b0, 2'b00, 32'h0BAD_F00D}) begin fails++; $display("FAIL bp_read_hold%0d: got %b/%b/%h expected 1/0/0badf00d", k, rvalid, arready, rdata); end
            step();
        end
        rready = 1;
        step();
        rready = 0;
        tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL bp_read_done: got %b expected 0", rvalid); end
    endtask
    task automatic test_read_during_commit();
        awaddr = 32'h8; awvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
        araddr = 32'h8; arvalid = 1;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        model[2] = 32'h1234_5678;
        tests++; if (rdata !== RV || rvalid !== 1'b1) begin fails++; $display("FAIL rdc_old_value: got %h expected %h", rdata, RV); end
        tests++; if (reg_q !== packed_model() || reg_wr_stb !== 8'h04) begin fails++; $display("FAIL rdc_commit: got %h/%h expected %h/04", reg_q, reg_wr_stb, packed_model()); end
        bready = 1; rready = 1;
        step();
        bready = 0; rready = 0;
        arvalid = 1;
        step();
        arvalid = 0;
        tests++; if (rdata !== 32'h1234_5678 || rresp !== 2'b00) begin fails++; $display("FAIL rdc_new_value: got %h/%b expected 12345678/00", rdata, rresp); end
        rready = 1;
        step();
        rready = 0;
    endtask
    task automatic test_reset_mid();
        awaddr = 32'h10; awvalid = 1;
        step();
        awvalid = 0;
        tests++; if ({awready, wready} !== 2'b01) begin fails++; $display("FAIL mid_have_a: got %b expected 01", {awready, wready}); end
        wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1;
        arst = 1;
        #1;
        for (int i = 0; i < N; i++) model[i] = RV;
        tests++; if ({awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr_stb} !== '0) begin fails++; $display("FAIL mid_async_outputs: got %h expected 0", {awready, wready, arready, bvalid, rvalid, bresp, rresp, rdata, reg_wr_stb}); end
        tests++; if (reg_q !== packed_model()) begin fails++; $display("FAIL mid_async_regs: got %h expected %h", reg_q, packed_model()); end
        step();
        wvalid = 0;
        arst = 0;
        step();
        step();
        tests++; if ({bvalid, reg_wr_stb} !== 9'h0 || reg_q !== packed_model()) begin fails++; $display("FAIL mid_after_release: got %b/%h expected 0/%h", bvalid, reg_q, packed_model()); end
        tests++; if ({awready, wready, arready} !== 3'b111) begin fails++; $display("FAIL mid_ready: got %b expected 111", {awready, wready, arready}); end
    endtask
    initial begin
        test_reset();
        test_same_cycle_write();
        test_data_first();
        test_out_of_range();
        test_backpressure();
        test_read_during_commit();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
